// File: rtl/count_display_driver_pkg.sv
// Shared constants for the count display driver: 7-segment codes, FSM
// encodings and the digit encoder.
package count_display_driver_pkg;

    // Segment codes in {g,f,e,d,c,b,a} order, active high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/count_display_driver_if.sv
// Bundle between the count source / display pins and the display driver.
interface count_display_driver_if #(
    parameter int COUNT_W = 4
) ();
    logic [COUNT_W-1:0] count;
    logic               en;
    logic [6:0]         seg;
    logic [1:0]         an;
    logic               changed;
    logic               busy;

    modport master (
        output count, en,
        input  seg, an, changed, busy
    );

    modport slave (
        input  count, en,
        output seg, an, changed, busy
    );
endinterface

// File: rtl/count_display_driver_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, COUNT_W steps
// per conversion, result held until the next start.
module count_display_driver_bin2bcd_seq #(
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [COUNT_W-1:0] bin_i,
    output logic               done_o,
    output logic [3:0]         tens_o,
    output logic [3:0]         units_o
);
    localparam int SR_W  = COUNT_W + 8;
    localparam int CNT_W = $clog2(COUNT_W + 1);

    logic [SR_W-1:0]  sr_q, sr_d, sr_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             last_shift;

    assign last_shift = active_q && (cnt_q == CNT_W'(COUNT_W - 1));

    // NOTE: every variable written in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < 2; i++) begin
            if (sr_adj[COUNT_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[COUNT_W + 4*i +: 4] = sr_adj[COUNT_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            sr_d     = {8'd0, bin_i};
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            sr_d  = {sr_adj[SR_W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (last_shift) begin
                active_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign done_o  = last_shift;
    assign tens_o  = sr_q[COUNT_W + 4 +: 4];
    assign units_o = sr_q[COUNT_W +: 4];

endmodule

// File: rtl/count_display_driver.sv
// Samples a binary count, converts it to two BCD digits and scans them onto
// a multiplexed 2-digit 7-segment display; pulses 'changed' on each commit.
module count_display_driver
    import count_display_driver_pkg::*;
#(
    parameter int COUNT_W        = 4,
    parameter int REFRESH_DIV    = 4,
    parameter int LEAD_BLANK     = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input logic                  clk,
    input logic                  rst,
    count_display_driver_if.slave bus
);
    localparam int   PRE_W = $clog2(REFRESH_DIV);
    localparam logic INV   = (SEG_ACTIVE_LOW != 0);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, last_q, last_d;
    logic [3:0]         tens_q, tens_d, units_q, units_d;
    logic               changed_q, changed_d, busy_q, busy_d;
    logic               conv_start, conv_done;
    logic [3:0]         conv_tens, conv_units;

    logic [PRE_W-1:0]   presc_q, presc_d;
    logic               sel_q, sel_d;
    logic [6:0]         seg_q, seg_d, seg_raw;
    logic [1:0]         an_q, an_d, an_raw;

    count_display_driver_bin2bcd_seq #(.COUNT_W(COUNT_W)) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_start),
        .bin_i   (count_q),
        .done_o  (conv_done),
        .tens_o  (conv_tens),
        .units_o (conv_units)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        tens_d     = tens_q;
        units_d    = units_q;
        changed_d  = 1'b0;
        busy_d     = busy_q;
        conv_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != last_q) begin
                    conv_start = 1'b1;
                    last_d     = count_q;
                    busy_d     = 1'b1;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                tens_d    = conv_tens;
                units_d   = conv_units;
                changed_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            last_q    <= '0;
            tens_q    <= 4'd0;
            units_q   <= 4'd0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= bus.count;
            last_q    <= last_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
        end
    end

    // Disabled display parks the scan on units so re-enable starts a full units phase.
    always_comb begin
        presc_d = presc_q;
        sel_d   = sel_q;
        seg_raw = SEG_BLANK;
        an_raw  = 2'b00;
        if (!bus.en) begin
            presc_d = '0;
            sel_d   = 1'b0;
        end else begin
            if (sel_q) begin
                an_raw  = 2'b10;
                seg_raw = ((LEAD_BLANK != 0) && (tens_q == 4'd0)) ? SEG_BLANK
                                                                  : seg_encode(tens_q);
            end else begin
                an_raw  = 2'b01;
                seg_raw = seg_encode(units_q);
            end
            if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
                presc_d = '0;
                sel_d   = ~sel_q;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        seg_d = seg_raw ^ {7{INV}};
        an_d  = an_raw ^ {2{INV}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            sel_q   <= 1'b0;
            seg_q   <= {7{INV}};
            an_q    <= {2{INV}};
        end else begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.changed = changed_q;
    assign bus.busy    = busy_q;

endmodule
